// File: rtl/vita49_pkg.sv
// vita49_pkg: state encoding, pack_ctrl/status bit positions and ctrl word helper for the VITA-49 tx scheduler.
package vita49_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int CTRL_START    = 0;
    localparam int CTRL_RESET    = 1;
    localparam int CTRL_PASSTHRU = 2;
    localparam int CTRL_TRAILER  = 3;

    localparam int STAT_LATE = 3;
    localparam int STAT_TOUT = 4;
    localparam int STAT_DONE = 5;

    function automatic logic [31:0] ctrl_word(input state_t s, input logic pt, input logic tr);
        logic [31:0] w;
        w                = '0;
        w[CTRL_START]    = (s == ST_RUN);
        w[CTRL_RESET]    = (s == ST_IDLE) || (s == ST_FLUSH) || (s == ST_DONE);
        w[CTRL_PASSTHRU] = pt;
        w[CTRL_TRAILER]  = tr;
        return w;
    endfunction

endpackage

// File: rtl/vita49_tx_sched_if.sv
// vita49_tx_sched_if: tap of the packer's M_AXIS handshake as seen by the scheduler.
interface vita49_tx_sched_if;
    logic tvalid;
    logic tready;
    logic tlast;
    modport master (output tvalid, tready, tlast);
    modport slave  (input  tvalid, tready, tlast);
endinterface

// File: rtl/vita49_time_cmp.sv
// vita49_time_cmp: registered 96-bit unsigned now >= start compare, 1-cycle latency.
module vita49_time_cmp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [95:0] now,
    input  logic [95:0] start,
    output logic        ge
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ge <= 1'b0;
        else        ge <= now >= start;
    end
endmodule

// File: rtl/vita49_tx_sched.sv
// vita49_tx_sched: timed VITA-49 packer scheduler (arm, wait for start time, run N packets, flush).
// Optional stall watchdog enabled by defining VITA49_TX_SCHED_TIMEOUT_EN.
module vita49_tx_sched
    import vita49_pkg::*;
#(
    parameter int FLUSH_CYCLES   = 4,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic             AXIS_ACLK,
    input  logic             AXIS_ARESETN,
    input  logic             cmd_arm,
    input  logic             cmd_abort,
    input  logic [31:0]      cfg_start_sec,
    input  logic [63:0]      cfg_start_fsec,
    input  logic [CNT_W-1:0] cfg_num_pkts,
    input  logic             cfg_passthrough,
    input  logic             cfg_trailer_en,
    input  logic [31:0]      timestamp_sec,
    input  logic [63:0]      timestamp_fsec,
    vita49_tx_sched_if.slave mon,
    output logic [31:0]      pack_ctrl,
    output logic [31:0]      status,
    output logic [CNT_W-1:0] pkt_count
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    if (FLUSH_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("FLUSH_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    state_t           state, state_n;
    logic             late, late_n, tout, tout_n;
    logic             first, in_pkt, time_ge;
    logic             xfr, pend, final_pkt, to_hit;
    logic [CNT_W-1:0] cnt_inc, cnt_n;
    logic [FW-1:0]    fcnt;
    logic [31:0]      status_n;

    assign xfr       = mon.tvalid & mon.tready;
    assign pend      = xfr & mon.tlast;
    assign cnt_inc   = pkt_count + 1'b1;
    assign final_pkt = pend && (cfg_num_pkts != '0) && (cnt_inc == cfg_num_pkts);

    vita49_time_cmp u_cmp (
        .clk   (AXIS_ACLK),
        .rst_n (AXIS_ARESETN),
        .now   ({timestamp_sec, timestamp_fsec}),
        .start ({cfg_start_sec, cfg_start_fsec}),
        .ge    (time_ge)
    );

`ifdef VITA49_TX_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          active;
    assign active = (state == ST_RUN) || (state == ST_DRAIN);
    assign to_hit = active && !xfr && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) to_cnt <= '0;
        else               to_cnt <= (active && !xfr) ? to_cnt + 1'b1 : '0;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = pkt_count;
        late_n  = late;
        tout_n  = tout;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (cmd_arm && !cmd_abort) begin
                    state_n = ST_ARMED;
                    cnt_n   = '0;
                    late_n  = 1'b0;
                    tout_n  = 1'b0;
                end
            end
            ST_ARMED: begin
                if (cmd_abort) state_n = ST_IDLE;
                else if (time_ge) begin
                    state_n = ST_RUN;
                    late_n  = late | first;
                end
            end
            ST_RUN: begin
                cnt_n   = pend ? cnt_inc : pkt_count;
                state_n = final_pkt ? ST_FLUSH : cmd_abort ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: begin
                cnt_n   = pend ? cnt_inc : pkt_count;
                state_n = (cmd_abort || pend || !in_pkt) ? ST_FLUSH : ST_DRAIN;
            end
            ST_FLUSH: state_n = (fcnt == FW'(FLUSH_CYCLES - 1)) ? ST_DONE : ST_FLUSH;
            default:  state_n = ST_IDLE;
        endcase
        if (to_hit) begin
            state_n = ST_FLUSH;
            tout_n  = 1'b1;
        end
    end

    always_comb begin
        status_n            = '0;
        status_n[2:0]       = state_n;
        status_n[STAT_LATE] = late_n;
        status_n[STAT_TOUT] = tout_n;
        status_n[STAT_DONE] = (state_n == ST_DONE);
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state     <= ST_IDLE;
            late      <= 1'b0;
            tout      <= 1'b0;
            first     <= 1'b0;
            in_pkt    <= 1'b0;
            fcnt      <= '0;
            pkt_count <= '0;
            pack_ctrl <= 32'h2;
            status    <= '0;
        end else begin
            state     <= state_n;
            late      <= late_n;
            tout      <= tout_n;
            first     <= (state_n == ST_ARMED) && (state != ST_ARMED);
            // a packer reset discards any partial packet, so forget it too
            in_pkt    <= (state_n == ST_FLUSH) ? 1'b0 : pend ? 1'b0 : xfr ? 1'b1 : in_pkt;
            fcnt      <= (state == ST_FLUSH) ? fcnt + 1'b1 : '0;
            pkt_count <= cnt_n;
            pack_ctrl <= ctrl_word(state_n, cfg_passthrough, cfg_trailer_en);
            status    <= status_n;
        end
    end

endmodule

// File: tb/tb_vita49_tx_sched.sv
// tb_vita49_tx_sched: directed self-checking bench for vita49_tx_sched with a packet-count scoreboard.
module tb_vita49_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_arm = 1'b0, cmd_abort = 1'b0;
    logic [31:0] cfg_start_sec;
    logic [63:0] cfg_start_fsec;
    logic [31:0] cfg_num_pkts;
    logic        cfg_passthrough = 1'b0, cfg_trailer_en = 1'b0;
    logic [95:0] ts;
    logic [31:0] pack_ctrl, status, pkt_count;
    logic        ramp = 1'b0;
    int          n_chk = 0, n_fail = 0, cyc = 0;
    logic [31:0] exp_q[$];

    vita49_tx_sched_if mon_if ();

    always #5 clk = ~clk;

    vita49_tx_sched #(.FLUSH_CYCLES(4), .CNT_W(32), .TIMEOUT_CYCLES(16)) dut (
        .AXIS_ACLK       (clk),
        .AXIS_ARESETN    (rst_n),
        .cmd_arm         (cmd_arm),
        .cmd_abort       (cmd_abort),
        .cfg_start_sec   (cfg_start_sec),
        .cfg_start_fsec  (cfg_start_fsec),
        .cfg_num_pkts    (cfg_num_pkts),
        .cfg_passthrough (cfg_passthrough),
        .cfg_trailer_en  (cfg_trailer_en),
        .timestamp_sec   (ts[95:64]),
        .timestamp_fsec  (ts[63:0]),
        .mon             (mon_if.slave),
        .pack_ctrl       (pack_ctrl),
        .status          (status),
        .pkt_count       (pkt_count)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (ramp) ts = ts + 96'd1;
    endtask

    task automatic pulse_arm();
        cmd_arm = 1'b1;
        step();
        cmd_arm = 1'b0;
    endtask

    task automatic pulse_abort();
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
    endtask

    task automatic send(input int words, input bit end_pkt, input int exp_cnt);
        for (int w = 0; w < words; w++) begin
            mon_if.tvalid = 1'b1;
            mon_if.tready = 1'b1;
            mon_if.tlast  = end_pkt && (w == words - 1);
            if (mon_if.tlast) exp_q.push_back(32'(exp_cnt));
            step();
            if (mon_if.tlast) chk("pkt_count", 96'(pkt_count), 96'(exp_q.pop_front()));
        end
        mon_if.tvalid = 1'b0;
        mon_if.tlast  = 1'b0;
    endtask

    task automatic wait_state(input int s, input string tag);
        for (int i = 0; i < 50; i++) begin
            if (int'(status[2:0]) == s) break;
            step();
        end
        chk(tag, 96'(status[2:0]), 96'(s));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int hit, st, fl, rc;
        mon_if.tvalid = 1'b0;
        mon_if.tready = 1'b1;
        mon_if.tlast  = 1'b0;
        ts = {32'd9, 64'hFFFF_FFFF_FFFF_FFF0};
        cfg_start_sec  = 32'd10;
        cfg_start_fsec = 64'd0;
        cfg_num_pkts   = 32'd3;
        cfg_passthrough = 1'b1;
        cfg_trailer_en  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_status", 96'(status), 96'h0);
        chk("rst_pack_ctrl", 96'(pack_ctrl), 96'h2);
        chk("rst_pkt_count", 96'(pkt_count), 96'h0);
        rst_n = 1'b1;
        step();

        // start time reached while armed
        ramp = 1'b1;
        pulse_arm();
        hit = -1;
        st  = -1;
        for (int i = 0; i < 60; i++) begin
            if (ts == {32'd10, 64'd0} && hit < 0) hit = cyc;
            if (pack_ctrl[0] && st < 0) st = cyc;
            if (st >= 0) break;
            step();
        end
        ramp = 1'b0;
        chk("start_latency", 96'(st - hit), 96'd2);
        chk("ontime_late_err", 96'(status[3]), 96'd0);
        chk("run_pack_ctrl", 96'(pack_ctrl), 96'hD);

        // three packets then flush
        send(8, 1, 1);
        send(8, 1, 2);
        send(8, 1, 3);
        fl = 0;
        for (int i = 0; i < 20; i++) begin
            if (status[2:0] == 3'd5) break;
            if (status[2:0] == 3'd4 && pack_ctrl[1]) fl++;
            step();
        end
        chk("flush_cycles", 96'(fl), 96'd4);
        chk("done_status", 96'(status), 96'h25);
        chk("done_pack_ctrl", 96'(pack_ctrl), 96'hE);

        // late start, abort mid-packet drains to tlast
        cfg_start_sec   = 32'd5;
        cfg_num_pkts    = 32'd0;
        cfg_passthrough = 1'b0;
        cfg_trailer_en  = 1'b0;
        pulse_arm();
        wait_state(2, "late_run");
        chk("late_err", 96'(status[3]), 96'd1);
        send(3, 0, 0);
        pulse_abort();
        chk("abort_drain", 96'(status[2:0]), 96'd3);
        send(3, 0, 0);
        chk("drain_wait", 96'(status[2:0]), 96'd3);
        send(1, 1, 1);
        chk("drain_flush", 96'(status[2:0]), 96'd4);
        wait_state(5, "drain_done");

        // double abort truncates the packet
        pulse_arm();
        wait_state(2, "abort2_run");
        send(2, 0, 0);
        pulse_abort();
        chk("abort1_drain", 96'(status[2:0]), 96'd3);
        pulse_abort();
        chk("abort2_flush", 96'(status[2:0]), 96'd4);
        chk("abort2_count", 96'(pkt_count), 96'd0);
        wait_state(5, "abort2_done");

        // asynchronous reset mid-packet
        pulse_arm();
        wait_state(2, "areset_run");
        send(4, 1, 1);
        send(2, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_pack_ctrl", 96'(pack_ctrl), 96'h2);
        chk("areset_count", 96'(pkt_count), 96'd0);
        chk("areset_status", 96'(status), 96'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // arm and abort together in IDLE
        cmd_arm   = 1'b1;
        cmd_abort = 1'b1;
        step();
        cmd_arm   = 1'b0;
        cmd_abort = 1'b0;
        chk("arm_abort_status", 96'(status), 96'h0);
        chk("arm_abort_pack_ctrl", 96'(pack_ctrl), 96'h2);
        step();
        chk("arm_abort_stay", 96'(status[2:0]), 96'd0);

`ifdef VITA49_TX_SCHED_TIMEOUT_EN
        pulse_arm();
        mon_if.tvalid = 1'b1;
        mon_if.tready = 1'b0;
        wait_state(2, "tout_run");
        rc = 0;
        for (int i = 0; i < 60; i++) begin
            if (status[2:0] == 3'd4) break;
            if (status[2:0] == 3'd2) rc++;
            step();
        end
        chk("tout_run_cycles", 96'(rc), 96'd16);
        chk("tout_flush", 96'(status[2:0]), 96'd4);
        chk("tout_err", 96'(status[4]), 96'd1);
        mon_if.tvalid = 1'b0;
        mon_if.tready = 1'b1;
`else
        rc = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
